// File: rtl/can_field_sequencer_if.sv
// Sample-point stream in, frame-field strobes and captured header fields out.
interface can_field_sequencer_if;
    logic       SP;
    logic       RX;
    logic       STUFF_BIT;
    logic       ERROR;
    logic       F_DATA;
    logic       F_CRC;
    logic       F_CRC_D;
    logic       F_ACK;
    logic       F_ACK_D;
    logic       F_EOF;
    logic       BUS_IDLE;
    logic       FRAME_DONE;
    logic       IDE;
    logic       RTR;
    logic [3:0] DLC;

    modport master (
        output SP, RX, STUFF_BIT, ERROR,
        input  F_DATA, F_CRC, F_CRC_D, F_ACK, F_ACK_D, F_EOF,
        input  BUS_IDLE, FRAME_DONE, IDE, RTR, DLC
    );

    modport slave (
        input  SP, RX, STUFF_BIT, ERROR,
        output F_DATA, F_CRC, F_CRC_D, F_ACK, F_ACK_D, F_EOF,
        output BUS_IDLE, FRAME_DONE, IDE, RTR, DLC
    );
endinterface

// File: rtl/can_field_sequencer.sv
// CAN bit-level frame sequencer: tracks the destuffed stream and flags
// which frame field the next sampled bit belongs to.
module can_field_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    can_field_sequencer_if.slave  bus
);

    typedef enum logic [4:0] {
        S_WAIT_IDLE, S_IDLE, S_ID_A, S_SRR_RTR, S_IDE,
        S_ID_B, S_RTR, S_R1, S_R0, S_DLC, S_DATA,
        S_CRC, S_CRC_D, S_ACK, S_ACK_D, S_EOF, S_IFS
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic       ide_q, ide_d;
    logic       rtr_q, rtr_d;
    logic       srr_q, srr_d;
    logic [3:0] dlc_q, dlc_d;
    logic       done_d, done_q;
    logic       idle_q;
    logic [5:0] flags_q;

    logic [3:0] dlc8;
    logic [6:0] data_last;
    logic [3:0] dlc_nx;
    logic       stuffed;

    assign dlc8      = dlc_q[3] ? 4'd8 : dlc_q;
    assign data_last = {dlc8, 3'b000} - 7'd1;
    assign dlc_nx    = {dlc_q[2:0], bus.RX};
    assign stuffed   = bus.STUFF_BIT &&
                       (state_q inside {S_ID_A, S_SRR_RTR, S_IDE,
                        S_ID_B, S_RTR, S_R1, S_R0, S_DLC,
                        S_DATA, S_CRC});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ide_d   = ide_q;
        rtr_d   = rtr_q;
        srr_d   = srr_q;
        dlc_d   = dlc_q;
        done_d  = 1'b0;
        if (bus.SP && !stuffed) begin
            cnt_d = cnt_q + 7'd1;
            unique case (state_q)
                S_WAIT_IDLE: begin
                    if (!bus.RX) begin
                        cnt_d = '0;
                    end else if (cnt_q == 7'd10) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                S_IDLE: begin
                    cnt_d = '0;
                    if (!bus.RX) begin
                        state_d = S_ID_A;
                        ide_d   = 1'b0;
                        rtr_d   = 1'b0;
                        dlc_d   = '0;
                    end
                end
                S_ID_A: begin
                    if (cnt_q == 7'd10) begin
                        state_d = S_SRR_RTR;
                        cnt_d   = '0;
                    end
                end
                S_SRR_RTR: begin
                    srr_d   = bus.RX;
                    state_d = S_IDE;
                    cnt_d   = '0;
                end
                // Standard frames take RTR from the SRR_RTR slot
                S_IDE: begin
                    ide_d = bus.RX;
                    cnt_d = '0;
                    if (bus.RX) begin
                        state_d = S_ID_B;
                    end else begin
                        rtr_d   = srr_q;
                        state_d = S_R0;
                    end
                end
                S_ID_B: begin
                    if (cnt_q == 7'd17) begin
                        state_d = S_RTR;
                        cnt_d   = '0;
                    end
                end
                S_RTR: begin
                    rtr_d   = bus.RX;
                    state_d = S_R1;
                    cnt_d   = '0;
                end
                S_R1: begin
                    state_d = S_R0;
                    cnt_d   = '0;
                end
                S_R0: begin
                    state_d = S_DLC;
                    cnt_d   = '0;
                end
                S_DLC: begin
                    dlc_d = dlc_nx;
                    if (cnt_q == 7'd3) begin
                        cnt_d = '0;
                        if (rtr_q || dlc_nx == 4'd0) begin
                            state_d = S_CRC;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt_q == data_last) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end
                end
                S_CRC: begin
                    if (cnt_q == 7'd14) begin
                        state_d = S_CRC_D;
                        cnt_d   = '0;
                    end
                end
                S_CRC_D: begin
                    state_d = S_ACK;
                    cnt_d   = '0;
                end
                S_ACK: begin
                    state_d = S_ACK_D;
                    cnt_d   = '0;
                end
                S_ACK_D: begin
                    state_d = S_EOF;
                    cnt_d   = '0;
                end
                S_EOF: begin
                    if (cnt_q == 7'd6) begin
                        state_d = S_IFS;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
                // Dominant in IFS: overload early, SOF on the last bit
                S_IFS: begin
                    if (!bus.RX) begin
                        cnt_d = '0;
                        if (cnt_q == 7'd2) begin
                            state_d = S_ID_A;
                            ide_d   = 1'b0;
                            rtr_d   = 1'b0;
                            dlc_d   = '0;
                        end else begin
                            state_d = S_WAIT_IDLE;
                        end
                    end else if (cnt_q == 7'd2) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_WAIT_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_WAIT_IDLE;
            cnt_q   <= '0;
            ide_q   <= 1'b0;
            rtr_q   <= 1'b0;
            srr_q   <= 1'b0;
            dlc_q   <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b0;
            flags_q <= '0;
        end else if (bus.ERROR) begin
            state_q <= S_WAIT_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            idle_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ide_q   <= ide_d;
            rtr_q   <= rtr_d;
            srr_q   <= srr_d;
            dlc_q   <= dlc_d;
            done_q  <= done_d;
            idle_q  <= (state_d == S_IDLE);
            flags_q <= {state_d == S_DATA,  state_d == S_CRC,
                        state_d == S_CRC_D, state_d == S_ACK,
                        state_d == S_ACK_D, state_d == S_EOF};
        end
    end

    assign bus.F_DATA     = flags_q[5];
    assign bus.F_CRC      = flags_q[4];
    assign bus.F_CRC_D    = flags_q[3];
    assign bus.F_ACK      = flags_q[2];
    assign bus.F_ACK_D    = flags_q[1];
    assign bus.F_EOF      = flags_q[0];
    assign bus.BUS_IDLE   = idle_q;
    assign bus.FRAME_DONE = done_q;
    assign bus.IDE        = ide_q;
    assign bus.RTR        = rtr_q;
    assign bus.DLC        = dlc_q;

endmodule
